// File: rtl/math_subtractor_multiword_seq.sv
// Sequential multi-word subtractor: an N-bit ripple-borrow stage reused once
// per chunk, least-significant chunk first, with the borrow carried between
// chunks in a register. Operands and result both use valid/ready handshakes.

`timescale 1ns/1ps

// N-bit ripple-borrow subtractor: difference = a - b - borrow_in.
module math_subtractor_ripple_carry #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic [N-1:0] difference,
    output logic         borrow_out
);

    // Bitwise full-subtractor chain, borrow propagating from bit 0 upward.
    always_comb begin
        logic bc;
        difference = '0;
        bc         = borrow_in;
        for (int i = 0; i < N; i++) begin
            difference[i] = a[i] ^ b[i] ^ bc;
            bc            = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc);
        end
        borrow_out = bc;
    end

endmodule

// State table
//   state  | meaning
//   IDLE   | waiting for operands, o_ready high
//   RUN    | one chunk subtracted per cycle, WORDS cycles total
//   DONE   | result held on o_difference/o_borrow_out until i_ready
module math_subtractor_multiword_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [N*WORDS-1:0] i_a,
    input  logic [N*WORDS-1:0] i_b,
    input  logic               i_borrow_in,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [N*WORDS-1:0] o_difference,
    output logic               o_borrow_out,
    output logic               o_busy
);

    localparam int W  = N * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res;
    logic            borrow;
    logic [N-1:0]    stage_diff;
    logic            stage_bout;
    logic            last_chunk;

    assign last_chunk = (cnt == CW'(WORDS - 1));

    math_subtractor_ripple_carry #(.N(N)) u_stage (
        .a          (a_sh[N-1:0]),
        .b          (b_sh[N-1:0]),
        .borrow_in  (borrow),
        .difference (stage_diff),
        .borrow_out (stage_bout)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, decoded purely from state.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (last_chunk) state_next = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                if (i_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand shifters, result accumulator, inter-chunk borrow and chunk counter.
    // The result fills from the top so that after WORDS shifts chunk 0 lands
    // in the least-significant position.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_sh   <= i_a;
                        b_sh   <= i_b;
                        borrow <= i_borrow_in;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> N;
                    b_sh   <= b_sh >> N;
                    res    <= (res >> N) | (W'(stage_diff) << (W - N));
                    borrow <= stage_bout;
                    if (!last_chunk) cnt <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_difference = res;
    assign o_borrow_out = borrow;

endmodule
